// File: rtl/jt12_pkg.sv
// Shared constants for the JT12 timer register block: register map, status bits, busy length.
package jt12_pkg;

    localparam logic [7:0] REG_TIMER_A_HI = 8'h24;
    localparam logic [7:0] REG_TIMER_A_LO = 8'h25;
    localparam logic [7:0] REG_TIMER_B    = 8'h26;
    localparam logic [7:0] REG_TIMER_CTRL = 8'h27;

    localparam int unsigned STATUS_BUSY   = 7;
    localparam int unsigned STATUS_FLAG_B = 1;
    localparam int unsigned STATUS_FLAG_A = 0;

    localparam int unsigned BUSY_CYCLES_DEF = 32;

    localparam logic [1:0] CSM_MODE = 2'b10;

endpackage

// File: rtl/jt12_busy.sv
// Write-busy timer: loads BUSY_CYCLES on start and counts down on clk_en.
module jt12_busy
    import jt12_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic start,
    output logic busy
);

    localparam int unsigned CntW = $clog2(BUSY_CYCLES + 1);

    logic [CntW-1:0] cnt;

    // A new start reloads even when it coincides with a clk_en decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= CntW'(BUSY_CYCLES);
            busy <= 1'b1;
        end else if (clk_en && busy) begin
            cnt <= cnt - CntW'(1);
            if (cnt == CntW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jt12_timer_regs.sv
// CPU-facing timer registers of the JT12: address/data decode, timer A/B setup, CSM key-on, status.
module jt12_timer_regs
    import jt12_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm,
    output logic       csm_keyon,
    output logic [7:0] dout
);

    logic       strobe;
    logic       strobe_q;
    logic       access;
    logic       data_acc;
    logic [7:0] reg_addr;
    logic       part;
    logic       busy;

    // strobe_q resets low so a strobe already held at reset release is not an access.
    assign strobe   = cs_n | wr_n;
    assign access   = strobe_q & ~strobe;
    assign data_acc = access & addr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q     <= 1'b0;
            reg_addr     <= '0;
            part         <= 1'b0;
            value_A      <= '0;
            value_B      <= '0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            csm          <= 1'b0;
            csm_keyon    <= 1'b0;
        end else begin
            strobe_q   <= strobe;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (access && !addr[0]) begin
                reg_addr <= din;
                part     <= addr[1];
            end
            if (data_acc && !part) begin
                case (reg_addr)
                    REG_TIMER_A_HI: value_A[9:2] <= din;
                    REG_TIMER_A_LO: value_A[1:0] <= din[1:0];
                    REG_TIMER_B:    value_B      <= din;
                    REG_TIMER_CTRL: begin
                        csm          <= (din[7:6] == CSM_MODE);
                        clr_flag_B   <= din[5];
                        clr_flag_A   <= din[4];
                        enable_irq_B <= din[3];
                        enable_irq_A <= din[2];
                        load_B       <= din[1];
                        load_A       <= din[0];
                    end
                    default: ;
                endcase
            end
            if (clk_en) begin
                csm_keyon <= overflow_A & csm;
            end
        end
    end

    jt12_busy #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_busy (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .start (data_acc),
        .busy  (busy)
    );

    always_comb begin
        dout                = 8'h00;
        dout[STATUS_BUSY]   = busy;
        dout[STATUS_FLAG_B] = flag_B;
        dout[STATUS_FLAG_A] = flag_A;
    end

endmodule

// File: tb/tb_jt12_timer_regs.sv
// Directed self-checking bench for jt12_timer_regs.
module tb_jt12_timer_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       enable_irq_A;
    logic       enable_irq_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic       csm;
    logic       csm_keyon;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    logic [33:0] all_out;
    assign all_out = {value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
                      clr_flag_A, clr_flag_B, csm, csm_keyon, dout};

    always #5 clk = ~clk;

    jt12_timer_regs #(
        .BUSY_CYCLES(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .addr        (addr),
        .din         (din),
        .flag_A      (flag_A),
        .flag_B      (flag_B),
        .overflow_A  (overflow_A),
        .value_A     (value_A),
        .value_B     (value_B),
        .load_A      (load_A),
        .load_B      (load_B),
        .enable_irq_A(enable_irq_A),
        .enable_irq_B(enable_irq_B),
        .clr_flag_A  (clr_flag_A),
        .clr_flag_B  (clr_flag_B),
        .csm         (csm),
        .csm_keyon   (csm_keyon),
        .dout        (dout)
    );

    // Strobe low across exactly one rising edge; returns half a clk after the access edge.
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (dout[7] === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (dout[7] !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b after %0d clk, required 0", dout[7], k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 2'b00; din = 8'h00;
        flag_A = 1'b0; flag_B = 1'b0; overflow_A = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_out !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dout_flags();
        flag_A = 1'b1; flag_B = 1'b0; addr = 2'b01;
        #1;
        n_cmp++;
        if (dout !== 8'h01) begin
            n_err++;
            $display("FAIL dout_flag_a: got %h, required 01", dout);
        end
        flag_A = 1'b0; flag_B = 1'b1; addr = 2'b10;
        #1;
        n_cmp++;
        if (dout !== 8'h02) begin
            n_err++;
            $display("FAIL dout_flag_b: got %h, required 02", dout);
        end
        flag_A = 1'b0; flag_B = 1'b0;
    endtask

    task automatic test_timer_values();
        cpu_write(2'b00, 8'h24);
        cpu_write(2'b01, 8'hAB);
        n_cmp++;
        if (value_A !== 10'h2AC) begin
            n_err++;
            $display("FAIL value_a_hi: got %h, required 2ac", value_A);
        end
        cpu_write(2'b00, 8'h25);
        cpu_write(2'b01, 8'h03);
        n_cmp++;
        if (value_A !== 10'h2AF) begin
            n_err++;
            $display("FAIL value_a_full: got %h, required 2af", value_A);
        end
        cpu_write(2'b00, 8'h26);
        cpu_write(2'b01, 8'h5C);
        n_cmp++;
        if (value_B !== 8'h5C) begin
            n_err++;
            $display("FAIL value_b: got %h, required 5c", value_B);
        end
    endtask

    task automatic test_ctrl();
        cpu_write(2'b00, 8'h27);
        cpu_write(2'b01, 8'h25);
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm}
            !== 7'b1010100) begin
            n_err++;
            $display("FAIL ctrl_25: got ldA,ldB,enA,enB,clrB,clrA,csm=%b, required 1010100",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm});
        end
        @(negedge clk);
        n_cmp++;
        if ({clr_flag_B, clr_flag_A} !== 2'b00) begin
            n_err++;
            $display("FAIL clr_pulse_width: got clrB,clrA=%b, required 00",
                     {clr_flag_B, clr_flag_A});
        end
        // 0x35 also has bit 4 set, so clr_flag_A pulses as well.
        cpu_write(2'b01, 8'h35);
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm}
            !== 7'b1010110) begin
            n_err++;
            $display("FAIL ctrl_35: got ldA,ldB,enA,enB,clrB,clrA,csm=%b, required 1010110",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm});
        end
        cpu_write(2'b01, 8'h4A);
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm}
            !== 7'b0101000) begin
            n_err++;
            $display("FAIL ctrl_4a: got ldA,ldB,enA,enB,clrB,clrA,csm=%b, required 0101000",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_B, clr_flag_A, csm});
        end
    endtask

    task automatic test_busy();
        int highs;
        logic s31, s32, s51, s52;
        clk_en = 1'b1;
        wait_idle();
        cpu_write(2'b00, 8'h10);
        n_cmp++;
        if (dout[7] !== 1'b0) begin
            n_err++;
            $display("FAIL addr_no_busy: got %b, required 0", dout[7]);
        end
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h00;
        highs = 0; s31 = 1'b0; s32 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin cs_n = 1'b1; wr_n = 1'b1; end
            if (dout[7] === 1'b1) highs++;
            if (i == 31) s31 = dout[7];
            if (i == 32) s32 = dout[7];
        end
        n_cmp++;
        if (highs != 32 || s31 !== 1'b1 || s32 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_single: got %0d clk (last=%b next=%b), required 32 (1,0)",
                     highs, s31, s32);
        end
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0;
        highs = 0; s51 = 1'b0; s52 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0 || i == 20) begin cs_n = 1'b1; wr_n = 1'b1; end
            if (i == 19) begin cs_n = 1'b0; wr_n = 1'b0; end
            if (dout[7] === 1'b1) highs++;
            if (i == 51) s51 = dout[7];
            if (i == 52) s52 = dout[7];
        end
        n_cmp++;
        if (highs != 52 || s51 !== 1'b1 || s52 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_retrigger: got %0d clk (last=%b next=%b), required 52 (1,0)",
                     highs, s51, s52);
        end
    endtask

    task automatic test_csm();
        clk_en = 1'b0;
        cpu_write(2'b00, 8'h27);
        cpu_write(2'b01, 8'h80);
        n_cmp++;
        if ({csm, csm_keyon} !== 2'b10) begin
            n_err++;
            $display("FAIL csm_set: got csm,keyon=%b, required 10", {csm, csm_keyon});
        end
        overflow_A = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_err++;
            $display("FAIL keyon_no_clk_en: got %b, required 0", csm_keyon);
        end
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0; overflow_A = 1'b0;
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_err++;
            $display("FAIL keyon_pulse: got %b, required 1", csm_keyon);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_err++;
            $display("FAIL keyon_hold: got %b, required 1", csm_keyon);
        end
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_err++;
            $display("FAIL keyon_drop: got %b, required 0", csm_keyon);
        end
        cpu_write(2'b01, 8'h00);
        overflow_A = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0; overflow_A = 1'b0;
        n_cmp++;
        if ({csm, csm_keyon} !== 2'b00) begin
            n_err++;
            $display("FAIL keyon_suppressed: got csm,keyon=%b, required 00", {csm, csm_keyon});
        end
        clk_en = 1'b1;
    endtask

    task automatic test_held_strobe();
        cpu_write(2'b00, 8'h26);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h11;
        @(negedge clk);
        din = 8'h22;
        repeat (9) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (value_B !== 8'h11) begin
            n_err++;
            $display("FAIL held_strobe: got value_B=%h, required 11", value_B);
        end
    endtask

    task automatic test_part();
        wait_idle();
        cpu_write(2'b10, 8'h24);
        cpu_write(2'b11, 8'hFF);
        n_cmp++;
        if (value_A !== 10'h2AF || dout[7] !== 1'b1) begin
            n_err++;
            $display("FAIL part1_ignored: got value_A=%h busy=%b, required 2af 1",
                     value_A, dout[7]);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if (all_out !== 34'd0) begin
            n_err++;
            $display("FAIL reset_mid_busy: got %h, required 0", all_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dout[7] !== 1'b0) begin
            n_err++;
            $display("FAIL held_across_reset: got busy=%b, required 0", dout[7]);
        end
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dout_flags();
        test_timer_values();
        test_ctrl();
        test_busy();
        test_csm();
        test_held_strobe();
        test_part();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
